// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Sized for the widest legal WIDTH; users slice down to their own width.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ALL_ONES = '1;
  localparam logic [MAX_W-1:0] MIN_VAL  = {1'b1, {(MAX_W-1){1'b0}}};

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result bundle between a requester and muldiv_iter.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             start;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output a, b, op, start, cancel, hi_we, lo_we,
                  input  hi, lo, busy, done);
  modport slave  (input  a, b, op, start, cancel, hi_we, lo_we,
                  output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared {upper, lower} work register:
// shift-add for multiply, shift-subtract-restore for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_p
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_p[2*WIDTH-1:WIDTH]} + (i_p[0] ? {1'b0, i_m} : '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    w_rem  = i_p[2*WIDTH-1:WIDTH-1];
    w_diff = w_rem - {1'b0, i_m};
    if (i_div) begin
      if (!w_diff[WIDTH]) o_p = {w_diff[WIDTH-1:0], i_p[WIDTH-2:0], 1'b1};
      else                o_p = {w_rem[WIDTH-1:0], i_p[WIDTH-2:0], 1'b0};
    end else begin
      o_p = {w_sum, i_p[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide with architectural HI/LO; one bit per cycle.
// Define MULDIV_ACC_EN to make MADD(U)/MSUB(U) accumulate into {HI,LO}.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);
  import muldiv_pkg::*;

  localparam logic [WIDTH-1:0] L_ONES   = ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_MIN    = MIN_VAL[MAX_W-1 -: WIDTH];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p, w_step, w_prod, w_res;
  logic [WIDTH-1:0]   r_m, r_a, r_hi, r_lo, w_abs_a, w_abs_b, w_quo, w_rem;
  op_e                r_op;
  logic               r_neg_q, r_neg_r, r_dz, r_ovf, r_busy, r_done;
  logic               w_sgn, w_a_neg, w_b_neg, w_idle, w_accept, w_wr_en, w_is_div;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_en  = w_idle && (bus.hi_we || bus.lo_we);
  assign w_accept = w_idle && bus.start && !bus.hi_we && !bus.lo_we;
  assign w_sgn    = ~bus.op[0];
  assign w_a_neg  = w_sgn && bus.a[WIDTH-1];
  assign w_b_neg  = w_sgn && bus.b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b  = w_b_neg ? -bus.b : bus.b;
  assign w_is_div = (r_op == DIV) || (r_op == DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_is_div),
    .i_p   (r_p),
    .i_m   (r_m),
    .o_p   (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (bus.cancel) w_next = S_IDLE;
               else if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sign correction and special divide cases, consumed only in FIX.
  always_comb begin
    w_prod = r_neg_q ? -r_p : r_p;
    w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    w_res  = w_prod;
    if (w_is_div) begin
      if (r_dz)       w_res = {r_a, L_ONES};
      else if (r_ovf) w_res = {{WIDTH{1'b0}}, L_MIN};
      else            w_res = {w_rem, w_quo};
    end
`ifdef MULDIV_ACC_EN
    else if (r_op[2]) begin
      w_res = r_op[1] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_op    <= MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_FIX) && !bus.cancel;
      if (w_accept) begin
        r_cnt   <= '0;
        r_p     <= {{WIDTH{1'b0}}, w_abs_a};
        r_m     <= w_abs_b;
        r_a     <= bus.a;
        r_op    <= bus.op;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz    <= (bus.b == '0);
        r_ovf   <= w_sgn && (bus.a == L_MIN) && (bus.b == L_ONES);
      end else if (r_state == S_RUN) begin
        r_p   <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_wr_en) begin
        if (bus.hi_we) r_hi <= bus.a;
        if (bus.lo_we) r_lo <= bus.a;
      end else if ((r_state == S_FIX) && !bus.cancel) begin
        {r_hi, r_lo} <= w_res;
      end
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32: vector table plus cancel/reset/write sequences.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wr(input logic hw, input logic lw, input logic [W-1:0] d);
    @(negedge clk);
    bus.a = d; bus.hi_we = hw; bus.lo_we = lw;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  // inj >= 0 drives a start plus hi/lo writes while busy, after edge inj.
  task automatic do_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cw, input int inj,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input string nm);
    int early = 0;
    int idle  = 0;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1; bus.cancel = cw;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    for (int k = 0; k <= W; k++) begin
      if (bus.done) early++;
      if (!bus.busy) idle++;
      if (k == inj) begin
        bus.start = 1'b1; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'd1; bus.op = MULTU;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(early + idle), 64'd0);
    chk({nm, " done"},    {63'd0, bus.done}, 64'd1);
    chk({nm, " busy"},    {63'd0, bus.busy}, 64'd0);
    chk({nm, " hi"},      {32'd0, bus.hi}, {32'd0, ehi});
    chk({nm, " lo"},      {32'd0, bus.lo}, {32'd0, elo});
    @(negedge clk);
    chk({nm, " done_once"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int dn;
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[3]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[10] = '{DIVU,  32'd3,        32'd0,        32'd3,        32'hFFFFFFFF};
    vecs[11] = '{DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[12] = '{MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[13] = '{MULTU, 32'h12345678, 32'd0,        32'd0,        32'd0};

    bus.a = '0; bus.b = '0; bus.op = MULT;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset hi",   {32'd0, bus.hi}, 64'd0);
    chk("reset lo",   {32'd0, bus.lo}, 64'd0);
    chk("reset busy", {63'd0, bus.busy}, 64'd0);
    chk("reset done", {63'd0, bus.done}, 64'd0);

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, -1, vecs[i].hi, vecs[i].lo,
            $sformatf("vec%0d", i));

    do_op(DIVU, 32'd9, 32'd3, 1'b1, -1, 32'd0, 32'd3, "cancel_with_start");
    do_op(DIVU, 32'd100, 32'd7, 1'b0, 5, 32'd2, 32'd14, "busy_ignore");

    wr(1'b1, 1'b1, 32'h55);
    chk("both_we hi", {32'd0, bus.hi}, 64'h55);
    chk("both_we lo", {32'd0, bus.lo}, 64'h55);

    wr(1'b1, 1'b0, 32'd0);
    wr(1'b0, 1'b1, 32'd10);
`ifdef MULDIV_ACC_EN
    do_op(MADD,  32'd3, 32'd4, 1'b0, -1, 32'd0, 32'd22, "madd");
    do_op(MSUBU, 32'd2, 32'd3, 1'b0, -1, 32'd0, 32'd16, "msubu");
`else
    do_op(MADD,  32'd3, 32'd4, 1'b0, -1, 32'd0, 32'd12, "madd");
    do_op(MSUBU, 32'd2, 32'd3, 1'b0, -1, 32'd0, 32'd6,  "msubu");
`endif

    // Cancel sampled at edge 10 of a DIVU.
    wr(1'b1, 1'b0, 32'hAAAA);
    wr(1'b0, 1'b1, 32'hBBBB);
    @(negedge clk);
    bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("cancel busy_before", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel busy_after", {63'd0, bus.busy}, 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("cancel no_done", 64'(dn), 64'd0);
    chk("cancel hi", {32'd0, bus.hi}, 64'hAAAA);
    chk("cancel lo", {32'd0, bus.lo}, 64'hBBBB);

    // Async reset at cycle 5 of a MULTU.
    @(negedge clk);
    bus.op = MULTU; bus.a = 32'h1234; bus.b = 32'h10; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid hi",   {32'd0, bus.hi}, 64'd0);
    chk("rst_mid lo",   {32'd0, bus.lo}, 64'd0);
    chk("rst_mid busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("rst_mid no_done", 64'(dn), 64'd0);

    // hi_we with start in IDLE: write wins, start dropped.
    @(negedge clk);
    bus.op = MULTU; bus.a = 32'h77; bus.b = 32'd3; bus.start = 1'b1; bus.hi_we = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("we_start hi",   {32'd0, bus.hi}, 64'h77);
    chk("we_start busy", {63'd0, bus.busy}, 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("we_start no_op", 64'(dn), 64'd0);
    chk("we_start lo",    {32'd0, bus.lo}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
